// File: rtl/cw_pkg.sv
// Shared definitions for the CW external-bus responder: command-word field
// positions, bus word widths and the responder state encoding.
package cw_pkg;

  localparam int CW_WORD_W  = 16;
  localparam int ADDR_HI_W  = 8;
  localparam int LEN_W      = 3;
  localparam int CMD_MARKER = 4;
  localparam int CMD_WE     = 3;
  localparam int CMD_LEN_HI = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_ACK,
    ST_RD_MEM,
    ST_RD_TURN,
    ST_RD_ACK,
    ST_WR_SAMPLE,
    ST_WR_MEM,
    ST_WR_ACK,
    ST_ERR,
    ST_END
  } cw_state_e;

endpackage

// File: rtl/cw_mem_responder_if.sv
// CW bus plus memory request/acknowledge port. Signal names are seen from the
// responder: i_* are driven towards it, o_* are driven by it.
interface cw_mem_responder_if
  import cw_pkg::*;
#(
  parameter int ADDR_W = 24
);

  logic                 i_cw_req;
  logic                 i_cw_dir;
  logic [CW_WORD_W-1:0] i_cw_io;
  logic [CW_WORD_W-1:0] o_cw_io;
  logic                 o_cw_io_oe;
  logic                 o_cw_ack;
  logic                 o_cw_err;
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [ADDR_W-1:0]    o_mem_addr;
  logic [CW_WORD_W-1:0] o_mem_wdata;
  logic                 i_mem_ack;
  logic [CW_WORD_W-1:0] i_mem_rdata;
  logic                 i_mem_err;

  // Responder side.
  modport slave (
    input  i_cw_req, i_cw_dir, i_cw_io, i_mem_ack, i_mem_rdata, i_mem_err,
    output o_cw_io, o_cw_io_oe, o_cw_ack, o_cw_err,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  // Initiator plus memory side.
  modport master (
    output i_cw_req, i_cw_dir, i_cw_io, i_mem_ack, i_mem_rdata, i_mem_err,
    input  o_cw_io, o_cw_io_oe, o_cw_ack, o_cw_err,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/cw_mem_responder.sv
// Memory-side end of the CW bus: decodes the two-word address phase, then
// serves read/write bursts of 16-bit words through a req/ack memory port.
module cw_mem_responder
  import cw_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  cw_mem_responder_if.slave bus
);

  cw_state_e            r_state;
  cw_state_e            w_next;

  logic [ADDR_HI_W-1:0] r_addr_hi;
  logic                 r_marker;
  logic                 r_we;
  logic [LEN_W-1:0]     r_cnt;
  logic [ADDR_W-1:0]    r_addr;
  logic [CW_WORD_W-1:0] r_rdata;
  logic [CW_WORD_W-1:0] r_wdata;
  logic                 r_first;
  logic                 r_abort;

  logic                 w_mem_done;
  logic                 w_abort;

  // A memory access completes on ack or err; err takes priority where it matters.
  assign w_mem_done = bus.i_mem_ack | bus.i_mem_err;
  // Initiator gave up: the pending memory access is drained without reporting.
  assign w_abort    = ~bus.i_cw_req | r_abort;

  assign bus.o_cw_io     = r_rdata;
  assign bus.o_mem_addr  = r_addr;
  assign bus.o_mem_wdata = r_wdata;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    w_next         = r_state;
    bus.o_cw_ack   = 1'b0;
    bus.o_cw_err   = 1'b0;
    bus.o_mem_req  = 1'b0;
    bus.o_mem_we   = 1'b0;
    bus.o_cw_io_oe = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_cw_req) w_next = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        if (!bus.i_cw_req)  w_next = ST_IDLE;
        else if (!r_marker) w_next = ST_ERR;
        else                w_next = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        bus.o_cw_ack = 1'b1;
        if (!bus.i_cw_req) w_next = ST_IDLE;
        else if (r_we)     w_next = ST_WR_SAMPLE;
        else               w_next = ST_RD_MEM;
      end
      ST_RD_MEM: begin
        bus.o_mem_req  = 1'b1;
        // The bus is already turned around once the first word has gone out.
        bus.o_cw_io_oe = bus.i_cw_dir & ~r_first & ~w_abort;
        if (w_abort) begin
          if (w_mem_done) w_next = ST_IDLE;
        end else if (bus.i_mem_err) begin
          w_next = ST_ERR;
        end else if (bus.i_mem_ack) begin
          // Skip the turnaround wait when the initiator already owns dir=1,
          // so zero-wait memory streams one word every two cycles.
          w_next = (!r_first && bus.i_cw_dir) ? ST_RD_ACK : ST_RD_TURN;
        end
      end
      ST_RD_TURN: begin
        bus.o_cw_io_oe = bus.i_cw_dir;
        if (!bus.i_cw_req)    w_next = ST_IDLE;
        else if (bus.i_cw_dir) w_next = ST_RD_ACK;
      end
      ST_RD_ACK: begin
        bus.o_cw_ack   = 1'b1;
        bus.o_cw_io_oe = bus.i_cw_dir;
        if (!bus.i_cw_req)  w_next = ST_IDLE;
        else if (r_cnt == '0) w_next = ST_END;
        else                w_next = ST_RD_MEM;
      end
      ST_WR_SAMPLE: begin
        if (!bus.i_cw_req) w_next = ST_IDLE;
        else               w_next = ST_WR_MEM;
      end
      ST_WR_MEM: begin
        bus.o_mem_req = 1'b1;
        bus.o_mem_we  = 1'b1;
        if (w_abort) begin
          if (w_mem_done) w_next = ST_IDLE;
        end else if (bus.i_mem_err) begin
          w_next = ST_ERR;
        end else if (bus.i_mem_ack) begin
          w_next = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        bus.o_cw_ack = 1'b1;
        if (!bus.i_cw_req)  w_next = ST_IDLE;
        else if (r_cnt == '0) w_next = ST_END;
        else                w_next = ST_WR_SAMPLE;
      end
      ST_ERR: begin
        bus.o_cw_err = 1'b1;
        if (!bus.i_cw_req) w_next = ST_IDLE;
        else               w_next = ST_END;
      end
      ST_END: begin
        if (!bus.i_cw_req) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address/command capture, burst bookkeeping and data holding registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_hi <= '0;
      r_marker  <= 1'b0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_wdata   <= '0;
      r_first   <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_abort <= 1'b0;
          if (bus.i_cw_req) begin
            r_addr_hi <= bus.i_cw_io[CW_WORD_W-1 -: ADDR_HI_W];
            r_marker  <= bus.i_cw_io[CMD_MARKER];
            r_we      <= bus.i_cw_io[CMD_WE];
            r_cnt     <= bus.i_cw_io[CMD_LEN_HI:0];
            r_first   <= 1'b1;
          end
        end
        ST_ADDR_LO: begin
          r_addr <= ADDR_W'({r_addr_hi, bus.i_cw_io});
        end
        ST_RD_MEM: begin
          if (w_abort) begin
            r_abort <= ~w_mem_done;
          end else if (bus.i_mem_ack && !bus.i_mem_err) begin
            r_rdata <= bus.i_mem_rdata;
          end
        end
        ST_WR_MEM: begin
          if (w_abort) r_abort <= ~w_mem_done;
        end
        ST_WR_SAMPLE: begin
          r_wdata <= bus.i_cw_io;
        end
        ST_RD_ACK, ST_WR_ACK: begin
          r_first <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - LEN_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
